// File: rtl/quot_rem_recombiner_pkg.sv
// Shared definitions for the quotient/remainder recombiner.
// Holds the FSM state encoding and a helper that sizes the rebuilt
// dividend from the quotient and divisor widths.
package quot_rem_recombiner_pkg;

    // FSM state encoding: IDLE=0, CALC=1, FINISH=2
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } rcb_state_e;

    // Width of the rebuilt dividend, quotient * divisor + remainder.
    // The sum never exceeds 2^A * (2^B - 1), so A+B bits always suffice.
    function automatic int prod_width(input int width_a, input int width_b);
        return width_a + width_b;
    endfunction

endpackage : quot_rem_recombiner_pkg

// File: rtl/quot_rem_recombiner.sv
// quot_rem_recombiner
// Rebuilds a dividend as quotient * divisor + remainder with an iterative
// shift-add datapath.  The quotient is consumed MSB first, in the same
// order the restoring divider chain produces it.  Also flags divider
// outputs whose remainder is not smaller than the divisor.
//
// Ports:
//   clk        rising-edge clock
//   arst       asynchronous active-high reset
//   en         start request, sampled only while idle
//   quotient   quotient to expand            [WIDTH_DIVIDEND-1:0]
//   divisor    divisor                       [WIDTH_DIVISOR-1:0]
//   remainder  remainder to add back         [WIDTH_DIVISOR-1:0]
//   busy       high while an operation runs (CALC and FINISH)
//   dividend_o rebuilt dividend, held until the next result
//   rem_err    remainder >= divisor for the held result
//   rdy        one-cycle result-valid pulse
module quot_rem_recombiner
    import quot_rem_recombiner_pkg::*;
#(
    parameter int WIDTH_DIVIDEND = 5,
    parameter int WIDTH_DIVISOR  = 3
) (
    input  logic                                   clk,
    input  logic                                   arst,
    input  logic                                   en,
    input  logic [WIDTH_DIVIDEND-1:0]              quotient,
    input  logic [WIDTH_DIVISOR-1:0]               divisor,
    input  logic [WIDTH_DIVISOR-1:0]               remainder,
    output logic                                   busy,
    output logic [WIDTH_DIVIDEND+WIDTH_DIVISOR-1:0] dividend_o,
    output logic                                   rem_err,
    output logic                                   rdy
);

    localparam int A  = WIDTH_DIVIDEND;
    localparam int B  = WIDTH_DIVISOR;
    localparam int PW = prod_width(WIDTH_DIVIDEND, WIDTH_DIVISOR);
    localparam int CW = $clog2(WIDTH_DIVIDEND + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH_DIVIDEND);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rcb_state_e     state_q, state_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [A-1:0]   q_sh_q, q_sh_d;
    logic [B-1:0]   div_sh_q, div_sh_d;
    logic [B-1:0]   rem_sh_q, rem_sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  dividend_q, dividend_d;
    logic           rem_err_q, rem_err_d;
    logic           rdy_q, rdy_d;
    logic           busy_q, busy_d;

    // Zero-extended operands for the adder stages
    logic [PW-1:0]  div_ext_s;
    logic [PW-1:0]  rem_ext_s;

    assign div_ext_s = {{A{1'b0}}, div_sh_q};
    assign rem_ext_s = {{A{1'b0}}, rem_sh_q};

    // Next-state, shift-add datapath and result capture
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        q_sh_d     = q_sh_q;
        div_sh_d   = div_sh_q;
        rem_sh_d   = rem_sh_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        rem_err_d  = rem_err_q;
        rdy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    // Shadow the operands so later input changes are ignored
                    q_sh_d   = quotient;
                    div_sh_d = divisor;
                    rem_sh_d = remainder;
                    acc_d    = '0;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Horner step: double the partial product, add divisor if
                // the current quotient bit (MSB of the shadow) is set
                acc_d  = {acc_q[PW-2:0], 1'b0} + (q_sh_q[A-1] ? div_ext_s : {PW{1'b0}});
                q_sh_d = {q_sh_q[A-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FINISH: begin
                dividend_d = acc_q + rem_ext_s;
                rem_err_d  = (rem_sh_q >= div_sh_q);
                rdy_d      = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset aborts any running operation
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            q_sh_q     <= '0;
            div_sh_q   <= '0;
            rem_sh_q   <= '0;
            cnt_q      <= '0;
            dividend_q <= '0;
            rem_err_q  <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            q_sh_q     <= q_sh_d;
            div_sh_q   <= div_sh_d;
            rem_sh_q   <= rem_sh_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            rem_err_q  <= rem_err_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign dividend_o = dividend_q;
    assign rem_err    = rem_err_q;
    assign rdy        = rdy_q;

endmodule : quot_rem_recombiner

// File: tb/tb_quot_rem_recombiner.sv
module tb_quot_rem_recombiner;

    logic       clk;
    logic       arst;
    logic       en;
    logic [4:0] quotient;
    logic [2:0] divisor;
    logic [2:0] remainder;
    logic       busy;
    logic [7:0] dividend_o;
    logic       rem_err;
    logic       rdy;

    int checks;
    int errors;

    quot_rem_recombiner #(
        .WIDTH_DIVIDEND(5),
        .WIDTH_DIVISOR (3)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .busy      (busy),
        .dividend_o(dividend_o),
        .rem_err   (rem_err),
        .rdy       (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: pulse en, wait for rdy, check latency/result
    task automatic run_op(input string tag, input int q, input int d, input int r,
                          input int exp_val, input int exp_err);
        int n;
        int lat;
        quotient  = 5'(q);
        divisor   = 3'(d);
        remainder = 3'(r);
        en        = 1'b1;
        tick();
        en  = 1'b0;
        lat = 0;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (rdy) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd6);
        check({tag, "_val"}, 32'(dividend_o), 32'(exp_val));
        check({tag, "_err"}, 32'(rem_err), 32'(exp_err));
        tick();
        check({tag, "_rdy1"}, 32'(rdy), 32'd0);
    endtask

    initial begin
        int rdy_cnt;
        int first_n;
        int second_n;
        int first_v;
        int second_v;

        checks    = 0;
        errors    = 0;
        arst      = 1'b1;
        en        = 1'b0;
        quotient  = 5'd0;
        divisor   = 3'd0;
        remainder = 3'd0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_val", 32'(dividend_o), 32'd0);
        check("rst_err", 32'(rem_err), 32'd0);
        arst = 1'b0;
        tick();

        // Directed vectors
        run_op("basic", 13, 5, 2, 67, 0);
        run_op("max_ok", 31, 7, 6, 223, 0);
        run_op("max_err", 31, 7, 7, 224, 1);
        run_op("div0", 9, 0, 3, 3, 1);
        run_op("q0", 0, 4, 1, 1, 0);

        // en pulse and input changes during CALC must be ignored
        quotient  = 5'd13;
        divisor   = 3'd5;
        remainder = 3'd2;
        en        = 1'b1;
        tick();
        en        = 1'b0;
        quotient  = 5'd1;
        divisor   = 3'd1;
        remainder = 3'd0;
        rdy_cnt   = 0;
        first_v   = 0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (n == 2) en = 1'b1;
            if (n == 3) en = 1'b0;
            if (rdy) begin
                rdy_cnt++;
                first_v = int'(dividend_o);
            end
        end
        check("midop_pulses", 32'(rdy_cnt), 32'd1);
        check("midop_val", 32'(first_v), 32'd67);

        // Back-to-back with en held high
        quotient  = 5'd6;
        divisor   = 3'd3;
        remainder = 3'd1;
        en        = 1'b1;
        tick();
        quotient  = 5'd2;
        divisor   = 3'd7;
        remainder = 3'd0;
        first_n   = 0;
        second_n  = 0;
        first_v   = 0;
        second_v  = 0;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (rdy) begin
                if (first_n == 0) begin
                    first_n = n;
                    first_v = int'(dividend_o);
                end else begin
                    second_n = n;
                    second_v = int'(dividend_o);
                end
            end
            if (n == 7) en = 1'b0;
        end
        check("b2b_first_n", 32'(first_n), 32'd6);
        check("b2b_first_v", 32'(first_v), 32'd19);
        check("b2b_second_n", 32'(second_n), 32'd13);
        check("b2b_second_v", 32'(second_v), 32'd14);

        // Async reset in CALC cycle 2 aborts the operation
        quotient  = 5'd13;
        divisor   = 3'd5;
        remainder = 3'd2;
        en        = 1'b1;
        tick();
        en = 1'b0;
        tick();
        #2;
        arst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_val", 32'(dividend_o), 32'd0);
        check("arst_err", 32'(rem_err), 32'd0);
        check("arst_rdy", 32'(rdy), 32'd0);
        tick();
        arst    = 1'b0;
        rdy_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (rdy) rdy_cnt++;
        end
        check("arst_no_rdy", 32'(rdy_cnt), 32'd0);
        run_op("restart", 5, 5, 4, 29, 0);

        // Exhaustive sweep of consistent divider outputs
        for (int q = 0; q < 32; q++) begin
            for (int d = 1; d < 8; d++) begin
                for (int r = 0; r < d; r++) begin
                    run_op("sweep", q, d, r, q * d + r, 0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_quot_rem_recombiner
